// File: rtl/led_scan_controller.sv
// Row-multiplexed LED matrix scanner for the Game of Life cell array.
// Snapshots cells/brightness once per frame, blanks between rows and PWMs each row drive.
module led_scan_controller #(
  parameter int unsigned N            = 5,
  parameter int unsigned DIVIDER_BITS = 12,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BRIGHT_BITS  = 4,
  localparam int unsigned RW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [N*N-1:0]         cells,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic [N-1:0]           rows,
  output logic [N-1:0]           cols,
  output logic [RW-1:0]          row_idx,
  output logic                   frame_start
);

  localparam int unsigned CW = DIVIDER_BITS + 1;
  localparam logic [CW-1:0] CntBlankLast = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CntDriveLast = CW'((1 << DIVIDER_BITS) - 1);
  localparam logic [RW-1:0] RowLast      = RW'(N - 1);
  localparam logic [N-1:0]  RowOne       = N'(1);

  typedef enum logic {StBlank, StDrive} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          row_q, row_d;
  logic [N*N-1:0]         snap_q, snap_d;
  logic [BRIGHT_BITS-1:0] bright_q, bright_d;
  logic [N-1:0]           rows_q, rows_d;
  logic [N-1:0]           cols_q, cols_d;
  logic [N-1:0]           row_cells;
  logic                   at_snap;
  logic                   lit;

  assign at_snap = (state_q == StBlank) && (row_q == '0) && (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    snap_d   = snap_q;
    bright_d = bright_q;

    if (ena) begin
      if (at_snap) begin
        snap_d   = cells;
        bright_d = brightness;
      end
      unique case (state_q)
        StBlank: begin
          if (cnt_q == CntBlankLast) begin
            state_d = StDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDrive: begin
          if (cnt_q == CntDriveLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            row_d   = (row_q == RowLast) ? '0 : row_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StBlank;
      endcase
    end

    // Outputs are decoded from next-state so the flops line up with the state they show.
    row_cells = '0;
    for (int r = 0; r < N; r++) begin
      if (row_d == RW'(r)) row_cells = snap_d[N*r +: N];
    end
    lit    = cnt_d[BRIGHT_BITS-1:0] < bright_d;
    rows_d = (state_d == StDrive) ? (RowOne << row_d) : '0;
    cols_d = (state_d == StDrive) ? ~(row_cells & {N{lit}}) : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StBlank;
      cnt_q    <= '0;
      row_q    <= '0;
      snap_q   <= '0;
      bright_q <= '0;
      rows_q   <= '0;
      cols_q   <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      snap_q   <= snap_d;
      bright_q <= bright_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
    end
  end

  // ena gates the display immediately; the held state keeps rows_q/cols_q valid for resume.
  assign rows        = ena ? rows_q : '0;
  assign cols        = ena ? cols_q : '1;
  assign row_idx     = row_q;
  assign frame_start = ena && !rst && at_snap;

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller with N=3, 16-cycle dwell, 2-cycle blank, 2-bit PWM.
module tb_led_scan_controller;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [8:0] cells;
  logic [1:0] brightness;
  logic [2:0] rows;
  logic [2:0] cols;
  logic [1:0] row_idx;
  logic       frame_start;

  int checks   = 0;
  int failures = 0;
  int t        = -100;

  led_scan_controller #(
    .N           (3),
    .DIVIDER_BITS(4),
    .BLANK_CYCLES(2),
    .BRIGHT_BITS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .cells      (cells),
    .brightness (brightness),
    .rows       (rows),
    .cols       (cols),
    .row_idx    (row_idx),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Move to 2 time units after the edge that starts cycle 'target'.
  task automatic goto(input int target);
    while (t < target) begin
      @(posedge clk);
      t++;
    end
    #2;
  endtask

  initial begin
    int lit_cnt;
    logic [2:0] r56, r74, r92;

    rst        = 1'b1;
    ena        = 1'b1;
    cells      = 9'b000_010_101;
    brightness = 2'd3;
    repeat (5) @(posedge clk);
    #2;
    #1;
    check("reset_rows", rows, 3'b000);
    check("reset_cols", cols, 3'b111);
    check("reset_row_idx", row_idx, 2'd0);
    check("reset_frame_start", frame_start, 1'b0);

    // Frame 0 starts at t=0: snapshot 000_010_101, brightness 3.
    rst = 1'b0;
    t   = 0;
    #1;
    check("t0_frame_start", frame_start, 1'b1);
    check("t0_rows", rows, 3'b000);
    goto(1); #1;
    check("t1_frame_start", frame_start, 1'b0);
    check("t1_rows", rows, 3'b000);
    goto(2); #1;
    check("t2_rows", rows, 3'b001);
    check("t2_cols_row0_lit", cols, 3'b010);
    lit_cnt = (cols !== 3'b111) ? 1 : 0;
    for (int k = 3; k < 18; k++) begin
      goto(k); #1;
      if (cols !== 3'b111) lit_cnt++;
      if (k == 5) check("t5_cols_cnt3_dark", cols, 3'b111);
      if (k == 6) check("t6_cols_cnt4_lit", cols, 3'b010);
    end
    check("row0_lit_cycles", lit_cnt, 12);
    check("t17_rows", rows, 3'b001);
    goto(18); #1;
    check("t18_rows", rows, 3'b000);
    check("t18_row_idx", row_idx, 2'd1);
    goto(20); #1;
    check("t20_rows", rows, 3'b010);
    check("t20_cols_row1", cols, 3'b101);
    goto(23); #1;
    check("t23_cols_row1_dark", cols, 3'b111);
    // Mid-frame cell change must not reach the display until the next snapshot.
    goto(25);
    cells = 9'b111_111_111;
    #1;
    goto(32); #1;
    check("t32_cols_row1_no_tear", cols, 3'b101);
    goto(35); #1;
    check("t35_rows", rows, 3'b010);
    goto(38); #1;
    check("t38_rows", rows, 3'b100);
    check("t38_cols_row2_dark", cols, 3'b111);
    goto(40);
    brightness = 2'd0;
    goto(53); #1;
    check("t53_frame_start", frame_start, 1'b0);

    // Frame 1: all cells alive but brightness 0 -> always dark while still scanning.
    goto(54); #1;
    check("t54_frame_start", frame_start, 1'b1);
    check("t54_row_idx", row_idx, 2'd0);
    lit_cnt = 0;
    r56 = 3'b000; r74 = 3'b000; r92 = 3'b000;
    for (int k = 54; k < 108; k++) begin
      goto(k); #1;
      if (cols !== 3'b111) lit_cnt++;
      if (k == 56) r56 = rows;
      if (k == 74) r74 = rows;
      if (k == 92) r92 = rows;
      if (k == 100) brightness = 2'd1;
    end
    check("frame1_lit_cycles", lit_cnt, 0);
    check("t56_rows", r56, 3'b001);
    check("t74_rows", r74, 3'b010);
    check("t92_rows", r92, 3'b100);

    // Frame 2 at t=108, brightness 1: lit only on cnt[1:0]==0.
    goto(108); #1;
    check("t108_frame_start", frame_start, 1'b1);
    goto(110); #1;
    check("t110_cols_lit", cols, 3'b000);
    goto(111); #1;
    check("t111_cols_dark", cols, 3'b111);

    // Freeze for 10 cycles mid-drive.
    goto(113);
    ena = 1'b0;
    #1;
    check("t113_rows_frozen", rows, 3'b000);
    check("t113_cols_frozen", cols, 3'b111);
    goto(122); #1;
    check("t122_rows_frozen", rows, 3'b000);
    check("t122_row_idx_held", row_idx, 2'd0);
    goto(123);
    ena = 1'b1;
    #1;
    check("t123_rows_resume", rows, 3'b001);
    check("t123_cols_cnt3", cols, 3'b111);
    goto(124); #1;
    check("t124_cols_cnt4", cols, 3'b000);
    goto(135); #1;
    check("t135_rows", rows, 3'b001);
    goto(136); #1;
    check("t136_rows", rows, 3'b000);
    check("t136_row_idx", row_idx, 2'd1);
    goto(171); #1;
    check("t171_frame_start", frame_start, 1'b0);

    // Freeze exactly at the snapshot point; snapshot moves to the first ena=1 cycle.
    goto(172);
    ena        = 1'b0;
    cells      = 9'b100_000_000;
    brightness = 2'd3;
    #1;
    check("t172_frame_start_frozen", frame_start, 1'b0);
    goto(173);
    ena = 1'b1;
    #1;
    check("t173_frame_start", frame_start, 1'b1);
    goto(175); #1;
    check("t175_rows", rows, 3'b001);
    check("t175_cols_row0_dark", cols, 3'b111);

    // Reset during row 1 drive.
    goto(198);
    rst = 1'b1;
    #1;
    check("t198_rows_before_reset", rows, 3'b010);
    goto(199); #1;
    check("t199_rows_reset", rows, 3'b000);
    check("t199_cols_reset", cols, 3'b111);
    check("t199_row_idx_reset", row_idx, 2'd0);
    check("t199_frame_start_reset", frame_start, 1'b0);
    goto(200);
    rst = 1'b0;
    #1;
    check("t200_frame_start", frame_start, 1'b1);
    goto(202); #1;
    check("t202_rows", rows, 3'b001);
    goto(238); #1;
    check("t238_rows", rows, 3'b100);
    check("t238_cols_row2", cols, 3'b011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
